// File: rtl/rob_pkg.sv
// Reorder-buffer geometry constants shared by the ROB and its neighbours.
package rob_pkg;

    localparam int ROB_DEPTH = 32;
    localparam int ROB_WIDTH = 3;
    localparam int ROB_IDX_W = $clog2(ROB_DEPTH);

endpackage

// File: rtl/sys_defs.sv
// Shared core-wide definitions: machine word width and the ROB entry packet
// that dispatch hands to the reorder buffer and retire reads back out.
package sys_defs;

    localparam int XLEN = 32;

    typedef struct packed {
        logic            valid;
        logic            is_store;
        logic [XLEN-1:0] pc;
        logic [4:0]      dest_reg;
    } ROB_ENTRY_PACKET;

endpackage

// File: rtl/rob_retire_sel.sv
// In-order retire selection over the head window: completion, occupancy,
// store-credit and mispredict gating, producing the retire mask, count and flush lane.
module rob_retire_sel #(
    parameter int WIDTH = 3,
    parameter int CNT_W = 6,
    parameter int SQ_W  = 2
) (
    input  logic [WIDTH-1:0] win_valid_i,
    input  logic [WIDTH-1:0] win_completed_i,
    input  logic [WIDTH-1:0] win_psn_i,
    input  logic [WIDTH-1:0] win_store_i,
    input  logic [CNT_W-1:0] count_i,
    input  logic [SQ_W-1:0]  sq_credit_i,
    output logic [WIDTH-1:0] retire_valid_o,
    output logic [SQ_W-1:0]  retire_cnt_o,
    output logic [WIDTH-1:0] flush_sel_o
);

    logic            chain;
    logic [SQ_W-1:0] stores;

    always_comb begin
        retire_valid_o = '0;
        retire_cnt_o   = '0;
        flush_sel_o    = '0;
        chain          = 1'b1;
        stores         = '0;
        for (int i = 0; i < WIDTH; i++) begin
            stores = stores + SQ_W'(win_store_i[i]);
            if (chain && win_valid_i[i] && win_completed_i[i] &&
                (CNT_W'(i) < count_i) && (stores <= sq_credit_i)) begin
                retire_valid_o[i] = 1'b1;
                retire_cnt_o      = SQ_W'(i + 1);
                // A mispredicted entry is the last one allowed out this cycle.
                if (win_psn_i[i]) begin
                    flush_sel_o[i] = 1'b1;
                    chain          = 1'b0;
                end
            end else begin
                chain = 1'b0;
            end
        end
    end

endmodule

// File: rtl/rob_nway.sv
// N-way reorder buffer with store-credit gated retire and self-generated mispredict flush.
// Optional ROB_TRACE_EN exposes entry array and pointers as debug outputs.
module rob_nway
    import sys_defs::*;
    import rob_pkg::*;
#(
    parameter int DEPTH  = ROB_DEPTH,
    parameter int WIDTH  = ROB_WIDTH,
    parameter int CWIDTH = 3,
    parameter int IDX_W  = $clog2(DEPTH)
) (
    input  logic                         clock,
    input  logic                         reset,
    input  ROB_ENTRY_PACKET              rob_in [WIDTH],
    output logic [IDX_W-1:0]             dispatch_index [WIDTH],
    output logic [WIDTH-1:0]             struct_stall,
    input  logic [CWIDTH-1:0]            complete_valid,
    input  logic [IDX_W-1:0]             complete_idx [CWIDTH],
    input  logic [CWIDTH-1:0]            precise_state_valid,
    input  logic [XLEN-1:0]              target_pc [CWIDTH],
    input  logic [$clog2(WIDTH+1)-1:0]   sq_credit,
    output logic [WIDTH-1:0]             retire_valid,
    output ROB_ENTRY_PACKET              retire_entry [WIDTH],
    output logic                         flush_valid,
    output logic [XLEN-1:0]              flush_pc
`ifdef ROB_TRACE_EN
    ,
    output ROB_ENTRY_PACKET              rob_entries_display [DEPTH],
    output logic [IDX_W-1:0]             head_display,
    output logic [IDX_W-1:0]             tail_display,
    output logic [IDX_W:0]               count_display
`endif
);

    localparam int SQ_W  = $clog2(WIDTH + 1);
    localparam int CNT_W = IDX_W + 1;

    ROB_ENTRY_PACKET  pkt_q [DEPTH];
    logic [XLEN-1:0]  tpc_q [DEPTH];
    logic [DEPTH-1:0] valid_q, completed_q, psn_q;
    logic [IDX_W-1:0] head_q, head_d, tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             flush_valid_q;
    logic [XLEN-1:0]  flush_pc_q;

    logic [IDX_W-1:0] win_idx [WIDTH];
    logic [WIDTH-1:0] win_valid, win_completed, win_psn, win_store;
    logic [WIDTH-1:0] accept, flush_sel;
    logic [SQ_W-1:0]  acc_cnt, ret_cnt;
    logic [CNT_W-1:0] free_slots;
    logic             acc_chain, flush_any;
    logic [XLEN-1:0]  flush_tpc;

    // Head window, allocation indices and stall mask, all from registered state.
    always_comb begin
        free_slots = CNT_W'(DEPTH) - count_q;
        for (int i = 0; i < WIDTH; i++) begin
            win_idx[i]        = head_q + IDX_W'(i);
            win_valid[i]      = valid_q[win_idx[i]];
            win_completed[i]  = completed_q[win_idx[i]];
            win_psn[i]        = psn_q[win_idx[i]];
            win_store[i]      = pkt_q[win_idx[i]].is_store;
            retire_entry[i]   = pkt_q[win_idx[i]];
            dispatch_index[i] = tail_q + IDX_W'(i);
            struct_stall[i]   = flush_valid_q | (free_slots < CNT_W'(i + 1));
        end
    end

    // Only a contiguous run of valid, unstalled lanes from lane 0 is accepted.
    always_comb begin
        accept    = '0;
        acc_cnt   = '0;
        acc_chain = 1'b1;
        for (int i = 0; i < WIDTH; i++) begin
            acc_chain = acc_chain & rob_in[i].valid & ~struct_stall[i];
            accept[i] = acc_chain;
            if (acc_chain) acc_cnt = SQ_W'(i + 1);
        end
    end

    rob_retire_sel #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W),
        .SQ_W  (SQ_W)
    ) u_retire_sel (
        .win_valid_i     (win_valid),
        .win_completed_i (win_completed),
        .win_psn_i       (win_psn),
        .win_store_i     (win_store),
        .count_i         (count_q),
        .sq_credit_i     (sq_credit),
        .retire_valid_o  (retire_valid),
        .retire_cnt_o    (ret_cnt),
        .flush_sel_o     (flush_sel)
    );

    always_comb begin
        flush_any = |flush_sel;
        flush_tpc = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (flush_sel[i]) flush_tpc = flush_tpc | tpc_q[win_idx[i]];
        end
        head_d  = head_q + IDX_W'(ret_cnt);
        tail_d  = tail_q + IDX_W'(acc_cnt);
        count_d = count_q + CNT_W'(acc_cnt) - CNT_W'(ret_cnt);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            head_q        <= '0;
            tail_q        <= '0;
            count_q       <= '0;
            valid_q       <= '0;
            completed_q   <= '0;
            psn_q         <= '0;
            flush_valid_q <= 1'b0;
            flush_pc_q    <= '0;
            for (int k = 0; k < DEPTH; k++) begin
                pkt_q[k] <= '0;
                tpc_q[k] <= '0;
            end
        end else if (flush_any) begin
            // Mispredict retires: drop everything, including this cycle's dispatch and completions.
            flush_valid_q <= 1'b1;
            flush_pc_q    <= flush_tpc;
            head_q        <= '0;
            tail_q        <= '0;
            count_q       <= '0;
            valid_q       <= '0;
            completed_q   <= '0;
            psn_q         <= '0;
        end else begin
            flush_valid_q <= 1'b0;
            // Ascending port order so the highest port wins a same-index collision.
            for (int j = 0; j < CWIDTH; j++) begin
                if (complete_valid[j] && valid_q[complete_idx[j]]) begin
                    completed_q[complete_idx[j]] <= 1'b1;
                    psn_q[complete_idx[j]]       <= precise_state_valid[j];
                    tpc_q[complete_idx[j]]       <= precise_state_valid[j] ? target_pc[j] : '0;
                end
            end
            for (int i = 0; i < WIDTH; i++) begin
                if (retire_valid[i]) begin
                    valid_q[win_idx[i]]     <= 1'b0;
                    completed_q[win_idx[i]] <= 1'b0;
                    psn_q[win_idx[i]]       <= 1'b0;
                end
            end
            for (int i = 0; i < WIDTH; i++) begin
                if (accept[i]) begin
                    pkt_q[dispatch_index[i]]       <= rob_in[i];
                    valid_q[dispatch_index[i]]     <= 1'b1;
                    completed_q[dispatch_index[i]] <= 1'b0;
                    psn_q[dispatch_index[i]]       <= 1'b0;
                    tpc_q[dispatch_index[i]]       <= '0;
                end
            end
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    assign flush_valid = flush_valid_q;
    assign flush_pc    = flush_pc_q;

`ifdef ROB_TRACE_EN
    always_comb begin
        for (int k = 0; k < DEPTH; k++) begin
            rob_entries_display[k]       = pkt_q[k];
            rob_entries_display[k].valid = valid_q[k];
        end
    end
    assign head_display  = head_q;
    assign tail_display  = tail_q;
    assign count_display = count_q;
`endif

endmodule

// File: tb/tb_rob_nway.sv
// Bench for rob_nway: table-driven fill, directed corner sequences, and
// randomized traffic checked against a queue-based ROB model.
module tb_rob_nway;
    import sys_defs::*;
    import rob_pkg::*;

    localparam int DEPTH  = ROB_DEPTH;
    localparam int WIDTH  = ROB_WIDTH;
    localparam int CWIDTH = 3;
    localparam int IDX_W  = ROB_IDX_W;
    localparam int SQ_W   = $clog2(WIDTH + 1);

    logic                clock = 1'b0;
    logic                reset;
    ROB_ENTRY_PACKET     rob_in [WIDTH];
    logic [IDX_W-1:0]    dispatch_index [WIDTH];
    logic [WIDTH-1:0]    struct_stall;
    logic [CWIDTH-1:0]   complete_valid;
    logic [IDX_W-1:0]    complete_idx [CWIDTH];
    logic [CWIDTH-1:0]   precise_state_valid;
    logic [XLEN-1:0]     target_pc [CWIDTH];
    logic [SQ_W-1:0]     sq_credit;
    logic [WIDTH-1:0]    retire_valid;
    ROB_ENTRY_PACKET     retire_entry [WIDTH];
    logic                flush_valid;
    logic [XLEN-1:0]     flush_pc;
`ifdef ROB_TRACE_EN
    ROB_ENTRY_PACKET     rob_entries_display [DEPTH];
    logic [IDX_W-1:0]    head_display, tail_display;
    logic [IDX_W:0]      count_display;
`endif

    rob_nway dut (
        .clock               (clock),
        .reset               (reset),
        .rob_in              (rob_in),
        .dispatch_index      (dispatch_index),
        .struct_stall        (struct_stall),
        .complete_valid      (complete_valid),
        .complete_idx        (complete_idx),
        .precise_state_valid (precise_state_valid),
        .target_pc           (target_pc),
        .sq_credit           (sq_credit),
        .retire_valid        (retire_valid),
        .retire_entry        (retire_entry),
        .flush_valid         (flush_valid),
        .flush_pc            (flush_pc)
`ifdef ROB_TRACE_EN
        ,
        .rob_entries_display (rob_entries_display),
        .head_display        (head_display),
        .tail_display        (tail_display),
        .count_display       (count_display)
`endif
    );

    always #5 clock = ~clock;

    // Reference model: in-flight entries oldest-first, plus the head position.
    typedef struct {
        logic [31:0] pc;
        logic        st;
        logic        comp;
        logic        psn;
        logic [31:0] tpc;
    } m_ent_t;

    m_ent_t      mq[$];
    int          m_head;
    logic        m_flush;
    logic [31:0] m_flush_pc;
    int          serial;
    int          checks;
    int          errors;

    typedef struct {
        logic [2:0] lanes;
        logic [2:0] stores;
        logic [4:0] exp_idx0;
        logic [2:0] exp_stall;
    } vec_t;
    vec_t vt [12];

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic clear_inputs();
        for (int i = 0; i < WIDTH; i++) rob_in[i] = '0;
        complete_valid      = '0;
        precise_state_valid = '0;
        for (int j = 0; j < CWIDTH; j++) begin
            complete_idx[j] = '0;
            target_pc[j]    = '0;
        end
        sq_credit = SQ_W'(3);
    endtask

    task automatic drive_dispatch(logic [2:0] lanes, logic [2:0] stores);
        for (int i = 0; i < WIDTH; i++) begin
            rob_in[i].valid    = lanes[i];
            rob_in[i].is_store = stores[i];
            rob_in[i].pc       = 32'h1000_0000 + 32'(serial) * 4;
            rob_in[i].dest_reg = 5'(serial);
            serial++;
        end
    endtask

    task automatic set_comp(int p, int idx, logic psv, logic [31:0] tpc);
        complete_valid[p]      = 1'b1;
        complete_idx[p]        = IDX_W'(idx);
        precise_state_valid[p] = psv;
        target_pc[p]           = tpc;
    endtask

    // Compare all outputs against the model for the current inputs, then advance one clock.
    task automatic cycle(string tag);
        logic [2:0] rv, est;
        int         nret, nacc, tail, stores, p;
        logic       fl;
        m_ent_t     e;
        #1;
        tail = (m_head + mq.size()) % DEPTH;
        for (int i = 0; i < WIDTH; i++) est[i] = m_flush || (DEPTH - mq.size() < i + 1);
        rv = '0; nret = 0; fl = 1'b0; stores = 0;
        for (int i = 0; i < WIDTH; i++) begin
            if (i >= mq.size()) break;
            stores += int'(mq[i].st);
            if (!mq[i].comp || stores > int'(sq_credit)) break;
            rv[i] = 1'b1;
            nret  = i + 1;
            if (mq[i].psn) begin
                fl = 1'b1;
                break;
            end
        end
        nacc = 0;
        for (int i = 0; i < WIDTH; i++) begin
            if (!rob_in[i].valid || est[i]) break;
            nacc++;
        end
        chk({tag, "_stall"}, struct_stall, est);
        for (int i = 0; i < WIDTH; i++)
            chk($sformatf("%s_didx%0d", tag, i), dispatch_index[i], (tail + i) % DEPTH);
        chk({tag, "_rv"}, retire_valid, rv);
        for (int i = 0; i < nret; i++)
            chk($sformatf("%s_rpc%0d", tag, i), retire_entry[i].pc, mq[i].pc);
        chk({tag, "_fv"}, flush_valid, m_flush);
        chk({tag, "_fpc"}, flush_pc, m_flush_pc);
        if (reset) begin
            mq.delete(); m_head = 0; m_flush = 1'b0; m_flush_pc = '0;
        end else if (fl) begin
            m_flush = 1'b1; m_flush_pc = mq[nret-1].tpc; mq.delete(); m_head = 0;
        end else begin
            m_flush = 1'b0;
            for (int j = 0; j < CWIDTH; j++) begin
                if (complete_valid[j]) begin
                    p = (int'(complete_idx[j]) - m_head + DEPTH) % DEPTH;
                    if (p < mq.size()) begin
                        e = mq[p];
                        e.comp = 1'b1;
                        e.psn  = precise_state_valid[j];
                        e.tpc  = precise_state_valid[j] ? target_pc[j] : 32'h0;
                        mq[p]  = e;
                    end
                end
            end
            for (int k = 0; k < nret; k++) void'(mq.pop_front());
            m_head = (m_head + nret) % DEPTH;
            for (int k = 0; k < nacc; k++) begin
                e.pc = rob_in[k].pc; e.st = rob_in[k].is_store;
                e.comp = 1'b0; e.psn = 1'b0; e.tpc = '0;
                mq.push_back(e);
            end
        end
        @(posedge clock);
        #1;
    endtask

    task automatic check_reset_state(string tag);
        #1;
        chk({tag, "_stall"}, struct_stall, 3'b000);
        chk({tag, "_rv"}, retire_valid, 3'b000);
        chk({tag, "_fv"}, flush_valid, 1'b0);
        chk({tag, "_fpc"}, flush_pc, 32'h0);
        for (int i = 0; i < WIDTH; i++) chk($sformatf("%s_didx%0d", tag, i), dispatch_index[i], i);
    endtask

    task automatic do_reset(string tag);
        clear_inputs();
        reset = 1'b1;
        cycle(tag);
        reset = 1'b0;
        check_reset_state({tag, "_after"});
    endtask

    initial begin
        checks = 0; errors = 0; serial = 0;
        m_head = 0; m_flush = 1'b0; m_flush_pc = '0;
        clear_inputs();
        reset = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
        check_reset_state("por");

        // Fill 32 entries three per cycle; entries 3..8 are stores.
        for (int r = 0; r < 11; r++) begin
            vt[r].lanes     = 3'b111;
            vt[r].stores    = (r == 1 || r == 2) ? 3'b111 : 3'b000;
            vt[r].exp_idx0  = 5'(3 * r);
            vt[r].exp_stall = (r == 10) ? 3'b100 : 3'b000;
        end
        vt[11].lanes = 3'b000; vt[11].stores = 3'b000;
        vt[11].exp_idx0 = 5'd0; vt[11].exp_stall = 3'b111;
        for (int r = 0; r < 12; r++) begin
            clear_inputs();
            drive_dispatch(vt[r].lanes, vt[r].stores);
            #1;
            chk($sformatf("vec%0d_idx0", r), dispatch_index[0], vt[r].exp_idx0);
            chk($sformatf("vec%0d_stall", r), struct_stall, vt[r].exp_stall);
            cycle($sformatf("vec%0d", r));
        end

        // Out-of-order completion: 0 and 2 done, only 0 may leave.
        clear_inputs(); set_comp(0, 0, 0, 0); set_comp(1, 2, 0, 0);
        #1; chk("ooo_rv0", retire_valid, 3'b000); cycle("ooo0");
        clear_inputs();
        #1; chk("ooo_rv1", retire_valid, 3'b001); chk("ooo_pc1", retire_entry[0].pc, 32'h1000_0000);
        cycle("ooo1");
        clear_inputs(); set_comp(0, 1, 0, 0);
        #1; chk("cnt31_stall", struct_stall, 3'b110); chk("ooo_rv2", retire_valid, 3'b000);
        cycle("ooo2");
        clear_inputs();
        #1; chk("ooo_rv3", retire_valid, 3'b011); cycle("ooo3");

        // Store-credit gating over stores 3..8.
        clear_inputs(); set_comp(0, 3, 0, 0); set_comp(1, 4, 0, 0); set_comp(2, 5, 0, 0);
        sq_credit = 2'd1; #1; chk("sq_rv0", retire_valid, 3'b000); cycle("sq0");
        clear_inputs(); set_comp(0, 6, 0, 0); set_comp(1, 7, 0, 0); set_comp(2, 8, 0, 0);
        sq_credit = 2'd1; #1; chk("sq_rv1", retire_valid, 3'b001); cycle("sq1");
        for (int k = 2; k < 4; k++) begin
            clear_inputs(); sq_credit = 2'd1;
            #1; chk($sformatf("sq_rv%0d", k), retire_valid, 3'b001); cycle("sqn");
        end
        clear_inputs(); sq_credit = 2'd0;
        #1; chk("sq_rv_zero", retire_valid, 3'b000); cycle("sqz");
        clear_inputs(); sq_credit = 2'd3;
        #1; chk("sq_rv_three", retire_valid, 3'b111); cycle("sq3");

        // Mispredict on entry 5 with 6 and 7 also completed.
        do_reset("rst1");
        for (int r = 0; r < 3; r++) begin
            clear_inputs(); drive_dispatch(3'b111, 3'b000); cycle("mfill");
        end
        clear_inputs(); set_comp(0, 0, 0, 0); set_comp(1, 1, 0, 0); set_comp(2, 2, 0, 0); cycle("mc0");
        clear_inputs(); set_comp(0, 3, 0, 0); set_comp(1, 4, 0, 0);
        #1; chk("mp_rv_a", retire_valid, 3'b111); cycle("mc1");
        clear_inputs(); set_comp(0, 5, 1, 32'h1000); set_comp(1, 6, 0, 0); set_comp(2, 7, 0, 0);
        #1; chk("mp_rv_b", retire_valid, 3'b011); cycle("mc2");
        clear_inputs(); drive_dispatch(3'b111, 3'b000); set_comp(0, 8, 0, 0);
        #1; chk("mp_rv_c", retire_valid, 3'b001); chk("mp_fv_pre", flush_valid, 1'b0); cycle("mc3");
        clear_inputs(); drive_dispatch(3'b111, 3'b000);
        #1; chk("mp_fv", flush_valid, 1'b1); chk("mp_fpc", flush_pc, 32'h1000);
        chk("mp_stall", struct_stall, 3'b111); chk("mp_didx0", dispatch_index[0], 0);
        chk("mp_rv_d", retire_valid, 3'b000); cycle("mc4");
        clear_inputs(); drive_dispatch(3'b111, 3'b000);
        #1; chk("post_fv", flush_valid, 1'b0); chk("post_stall", struct_stall, 3'b000);
        for (int i = 0; i < WIDTH; i++) chk($sformatf("post_didx%0d", i), dispatch_index[i], i);
        cycle("mc5");

        // Wrap-around: move head/tail to 30, then fill, retire 30,31,0 and refill.
        do_reset("rst2");
        for (int r = 0; r < 10; r++) begin
            clear_inputs(); drive_dispatch(3'b111, 3'b000); cycle("wfill");
        end
        for (int k = 0; k < 10; k++) begin
            clear_inputs();
            for (int p = 0; p < 3; p++) set_comp(p, 3 * k + p, 0, 0);
            cycle("wdrain");
        end
        clear_inputs(); cycle("wdrain_end");
        clear_inputs(); set_comp(0, 5, 0, 0); set_comp(1, 29, 1, 32'hdead);
        #1; chk("w_empty_idx", dispatch_index[0], 30); cycle("winv");
        clear_inputs();
        #1; chk("winv_rv", retire_valid, 3'b000); chk("winv_idx", dispatch_index[0], 30);
        chk("winv_stall", struct_stall, 3'b000); chk("winv_fv", flush_valid, 1'b0);
        for (int r = 0; r < 11; r++) begin
            clear_inputs(); drive_dispatch(3'b111, 3'b000); cycle("wfill2");
        end
        clear_inputs(); set_comp(0, 30, 0, 0); set_comp(1, 31, 0, 0); set_comp(2, 0, 0, 0);
        #1; chk("wfull_stall", struct_stall, 3'b111); chk("wfull_idx", dispatch_index[0], 30);
        cycle("wc");
        clear_inputs();
        #1; chk("wret_rv", retire_valid, 3'b111); cycle("wret");
        clear_inputs(); drive_dispatch(3'b111, 3'b000);
        #1; chk("wd_idx0", dispatch_index[0], 30); chk("wd_idx1", dispatch_index[1], 31);
        chk("wd_idx2", dispatch_index[2], 0); chk("wd_stall", struct_stall, 3'b000); cycle("wdisp");
        clear_inputs(); set_comp(0, 1, 1, 32'h2000);
        #1; chk("wt_idx0", dispatch_index[0], 1); chk("wt_stall", struct_stall, 3'b111); cycle("wt");

        // Reset wins over a mispredict retiring in the same cycle.
        clear_inputs();
        #1; chk("rp_rv", retire_valid, 3'b001);
        reset = 1'b1; cycle("rp"); reset = 1'b0;
        check_reset_state("rp_after");

        // Randomized traffic against the model.
        for (int n = 0; n < 1500; n++) begin
            clear_inputs();
            drive_dispatch(3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)));
            for (int j = 0; j < CWIDTH; j++) begin
                if ($urandom_range(0, 2) != 0) begin
                    if (mq.size() > 0 && $urandom_range(0, 7) != 0)
                        set_comp(j, (m_head + int'($urandom_range(0, mq.size() - 1))) % DEPTH,
                                 $urandom_range(0, 15) == 0, $urandom);
                    else
                        set_comp(j, int'($urandom_range(0, DEPTH - 1)), $urandom_range(0, 15) == 0, $urandom);
                end
            end
            sq_credit = SQ_W'($urandom_range(0, 3));
            reset = ($urandom_range(0, 299) == 0);
            cycle("rnd");
            reset = 1'b0;
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/rob_nway.md
# rob_nway

Parametrised N-way reorder buffer and the successor to the fixed 32-entry, 3-way ROB. It sits between dispatch and retire in the OoO core. Each cycle it allocates up to `WIDTH` in-order entries, accepts up to `CWIDTH` completion writes, and retires up to `WIDTH` completed entries in order. Retire is gated by store-queue credits, and the ROB generates its own branch-mispredict flush at retire time instead of relying on an external recover signal.

## Interface
Parameters:
- `DEPTH`, default 32: number of entries. Power of two, at least 2*`WIDTH`.
- `WIDTH`, default 3: number of dispatch lanes and retire lanes.
- `CWIDTH`, default 3: number of completion ports.
- `IDX_W`, default $clog2(`DEPTH`): width of an entry index.

Ports:
- `clock`, in, 1: clock.
- `reset`, in, 1: reset, synchronous, active-high.
- `rob_in`, in, `WIDTH` x ROB_ENTRY_PACKET: dispatch packets. Lane 0 is the oldest; each packet's `.valid` is its lane-valid.
- `dispatch_index`, out, `WIDTH` x `IDX_W`: entry index allocated to each lane.
- `struct_stall`, out, `WIDTH`: thermometer code; bit i set means lane i must not dispatch.
- `complete_valid`, in, `CWIDTH`: completion strobe per port.
- `complete_idx`, in, `CWIDTH` x `IDX_W`: entry being completed.
- `precise_state_valid`, in, `CWIDTH`: the completing entry mispredicted.
- `target_pc`, in, `CWIDTH` x `XLEN`: redirect PC for the completing entry.
- `sq_credit`, in, $clog2(`WIDTH`+1): number of stores the store queue can retire this cycle.
- `retire_valid`, out, `WIDTH`: retire strobe per lane. Lane 0 is the oldest.
- `retire_entry`, out, `WIDTH` x ROB_ENTRY_PACKET: the retiring entries.
- `flush_valid`, out, 1: registered one-cycle flush pulse.
- `flush_pc`, out, `XLEN`: registered redirect PC, meaningful while `flush_valid` is high.

## Operation
State:
- `head` and `tail`, each `IDX_W` bits, wrapping modulo `DEPTH`.
- `count`, `IDX_W`+1 bits, in the range 0..`DEPTH`. Full and empty are derived from `count` only.
- Per entry: `valid`, `completed`, `precise_state_need`, `target_pc`.

Dispatch:
- Valid lanes in `rob_in` must form a contiguous prefix starting at lane 0. A lane that breaks the prefix is dropped.
- `dispatch_index[i]` = (`tail` + i) mod `DEPTH`, computed combinationally from the registered `tail`.
- `struct_stall[i]` = (`DEPTH` − `count` < i+1), using the registered `count` only. Slots freed by retirement in the same cycle are not counted.
- `struct_stall` is forced to all-ones while `flush_valid` is high.
- A lane with `struct_stall[i]` set is ignored even if it is valid.
- Accepted entries are written with `completed`=0. `tail` advances by the number of accepted lanes.

Complete:
- On `complete_valid[j]`: set `completed`, latch `precise_state_need` = `precise_state_valid[j]`, and latch `target_pc` (the value written is `target_pc[j]` if `precise_state_valid[j]`, else 0).
- A completion to an entry whose `valid` is 0 is ignored.
- Two ports targeting the same index in one cycle: the higher port index wins.

Retire: lane i retires only if all of the following hold.
- Entry (`head` + i) is valid and completed.
- i < `count`.
- Lanes 0..i−1 all retire this cycle.
- The number of entries with `.is_store` set among lanes 0..i is ≤ `sq_credit`.
- No lower lane has `precise_state_need` set.
- `head` advances by the number of retiring lanes; retired entries have `valid` and `completed` cleared.
- `count_next` = `count` + accepted − retired.

Flush:
- If a retiring lane has `precise_state_need` set, that lane is the youngest to retire this cycle.
- On that edge: `flush_valid` is set to 1 and `flush_pc` to the lane's `target_pc`; `head`, `tail`, `count` and all `valid` bits are cleared.
- Dispatch and completions in that same cycle are discarded.

## Timing
- Reset values: `head`=`tail`=`count`=0 and all entries cleared. Outputs after reset: `retire_valid`=0, `struct_stall`=0, `flush_valid`=0, `flush_pc`=0, `dispatch_index[i]`=i.
- Reset takes priority over everything, including a pending flush. Reset mid-operation discards all entries.
- Completion to retire: at least 1 cycle. A completion written at edge t can retire in cycle t+1.
- `retire_valid` and `retire_entry` are combinational from registered state and `sq_credit`.
- Dispatch to retire: at least 2 cycles.
- `flush_valid` lasts exactly 1 cycle, the cycle after the mispredicted entry retires. Dispatch resumes in the cycle after `flush_valid`.
- Wrap-around: indices wrap modulo `DEPTH`. When `count`=`DEPTH`, `head`==`tail` and the ROB is full; when `count`=0, `head`==`tail` and the ROB is empty.

## Configuration
- `ROB_TRACE_EN` defined: adds output ports `rob_entries_display` (`DEPTH` x ROB_ENTRY_PACKET), `head_display`, `tail_display` and `count_display`, each driven directly from the state registers.
- `ROB_TRACE_EN` undefined: these ports and their logic are absent. Functional behaviour is identical with or without the macro.

## Structure
- ROB_ENTRY_PACKET stays in the shared sys_defs header.
- `ROB_DEPTH`, `ROB_WIDTH` and `ROB_IDX_W` are defined as constants in the shared `rob_pkg` package.
- Sub-module `rob_retire_sel`: combinational block that takes the `WIDTH` head-window entries, `count` and `sq_credit`, and produces `retire_valid`, the retire count and the flush-lane select.

## Test plan
- Reset, then dispatch 3 lanes per cycle for 11 cycles → `dispatch_index` 0..31 in order; after `count`=32 `struct_stall`=3'b111; with `count`=31 `struct_stall`=3'b110.
- Complete entries 0 and 2 only → retire lane 0 only (entry 0). Then complete entry 1 → next cycle entries 1 and 2 retire together.
- Head window holds 3 completed stores, `sq_credit`=1 → 1 retires per cycle over 3 cycles; with `sq_credit`=3 → all 3 retire in one cycle.
- Entry 5 completes with `precise_state_valid`=1 and `target_pc`=0x1000, and entries 5..7 are completed → only entry 5 retires; next cycle `flush_valid`=1, `flush_pc`=0x1000, `count`=0, `struct_stall`=3'b111; the cycle after, `dispatch_index`=0,1,2.
- Fill to wrap (`head`=30, `tail`=30, `count`=32), then retire 3 and dispatch 3 → `head`=1, `tail`=1, retired indices 30,31,0; completion to an invalid index leaves state unchanged.
- Assert `reset` while `flush_valid`=1 and the ROB is half full → all state zeroed and `flush_valid`=0 next cycle.
